baud_tick_gen: RTL and testbench
================================

Name: baud_tick_gen

Overview:
Parametrised, runtime-programmable baud-rate tick generator for the UART TX/RX datapaths. It replaces the fixed-divisor bit-clock generator with four additions:
- an integer plus fractional divisor, loadable at run time;
- a mid-bit sample tick and an end-of-bit tick;
- an in-frame bit index;
- a frame-complete pulse.

It sits between the register block (divisor configuration) and the UART shift engines, which consume its ticks as clock enables.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency, used only for the reset divisor.
BAUD_DEFAULT, 115200, baud rate selected out of reset.
DIV_W, 16, width of the integer divisor.
FRAC_W, 4, width of the fractional divisor (units of 1/2^FRAC_W cycle).
FRAME_BITS, 10, bits per frame (start + data + stop); legal range 2..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
en  in  1  run request; level-sensitive; frame timing restarts on the rising edge.
div_load  in  1  one-cycle strobe: capture div_int/div_frac.
div_int  in  DIV_W  integer cycles per bit.
div_frac  in  FRAC_W  fractional cycles per bit.
busy  out  1  high while state is RUN.
tick_mid  out  1  one-cycle pulse at the bit centre (sampling point).
tick_end  out  1  one-cycle pulse at the bit boundary.
bit_idx  out  4  index of the current bit in the frame, 0..FRAME_BITS-1.
frame_done  out  1  one-cycle pulse coincident with tick_end of the last bit.
cfg_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Reset values:
  - all outputs 0;
  - state IDLE; cnt=0; acc=0;
  - active divisor = CLK_FREQ_HZ/BAUD_DEFAULT (integer part), frac 0;
  - no pending load.
- States: IDLE and RUN.
  - IDLE->RUN on the edge that samples en=1 (edge E0). After E0: cnt=0, bit_idx=0, acc=0.
  - RUN->IDLE on any edge sampling en=0. This is an abort: cnt, bit_idx and acc are cleared; no tick_mid, tick_end or frame_done is issued on that edge.
- Bit period:
  - At each bit start, compute s = acc + frac (FRAC_W+1 bits).
  - period = div_int + s[FRAC_W]; acc <= s[FRAC_W-1:0].
  - Bit 0 of every frame starts with acc=0, so frames are deterministic.
- Counter: cnt counts 0..period-1 and wraps to 0 at the bit boundary. Width is DIV_W+1.
- Tick timing (all outputs registered, so pulses are visible one edge after the counter condition):
  - half = period>>1 (floor).
  - tick_mid is set on the edge where cnt==half, i.e. visible after edge E0+half+1 for bit 0.
  - tick_end is set on the edge where cnt==period-1, i.e. visible after edge E0+period.
  - bit_idx increments with tick_end.
- Frame end:
  - On tick_end of bit FRAME_BITS-1: frame_done=1, bit_idx wraps to 0, acc resets to 0.
  - If en is still 1, the next frame starts immediately with no gap cycle.
- Divisor load:
  - div_load with div_int<2 is rejected: cfg_err pulses on the next edge, active divisor unchanged.
  - A legal load in IDLE takes effect on the next edge.
  - A legal load in RUN is held pending and applied at the frame boundary (same edge as frame_done) or on abort.
  - A later load overwrites the pending value (last writer wins).
- Simultaneous events: div_load and en rising on the same edge. The new divisor is captured and the frame starts using the old divisor; the new divisor applies from the next frame.
- Outputs while busy=0: tick_mid and tick_end are never asserted.
- Reset mid-frame: all state clears immediately (asynchronously); no output pulses.

Decomposition:
- Package baud_pkg holds:
  - the default-divisor function div_from_baud(clk_hz, baud);
  - the FRAME_BITS legal-range constants;
  - the state encoding (IDLE=0, RUN=1).
- One sub-module is natural: baud_frac_acc. It contains the fractional accumulator and period computation, taking frac/div_int/bit_start and returning period.
- The counter, FSM and load logic remain in baud_tick_gen.

Test Plan:
1. Reset: rst=1 -> all outputs 0, busy=0. Then en=1 with no load -> active divisor 868 (100 MHz/115200); first tick_mid after edge E0+435, first tick_end after E0+868.
2. Integer divisor: load div_int=4, frac=0, FRAME_BITS=10, en=1 -> tick_mid after edges E0+3, 7, … 39; tick_end after edges 4, 8, … 40; frame_done together with the tick_end at edge 40; bit_idx returns to 0.
3. Fractional divisor: div_int=4, frac=8 (0.5) -> bit periods 4,5,4,5,…; frame_done after edge E0+45; a second back-to-back frame ends at E0+90.
4. Abort: en=0 on the edge after the 3rd tick_end (div 4) -> busy=0 on that edge, no further ticks, no frame_done. Re-assert en -> bit_idx restarts at 0.
5. Deferred load: in RUN with div 4, load div_int=6 during bit 2 -> remaining bits of the frame keep period 4; the next frame uses period 6 (first tick_end 6 cycles after the previous frame_done).
6. Illegal load: div_int=1 -> cfg_err pulses for 1 cycle; divisor unchanged (subsequent tick_end spacing still 4).

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants, state encoding and reset-divisor helper for the baud tick generator.
package baud_pkg;

    localparam int FRAME_BITS_MIN = 2;
    localparam int FRAME_BITS_MAX = 15;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int div_from_baud(input int clk_hz, input int baud);
        if (baud > 0) begin
            return clk_hz / baud;
        end else begin
            return 0;
        end
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional divisor accumulator: yields the length of the current bit in clock cycles.
module baud_frac_acc
    import baud_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] frac,
    input  logic              clear,
    input  logic              bit_start,
    output logic [DIV_W:0]    period
);

    logic [FRAC_W-1:0] acc_r;
    logic [FRAC_W:0]   sum_s;

    // Carry out of the fractional sum stretches the current bit by one cycle.
    always_comb begin
        sum_s  = {1'b0, acc_r} + {1'b0, frac};
        period = {1'b0, div_int} + {{DIV_W{1'b0}}, sum_s[FRAC_W]};
    end

    // Accumulator advances at each bit boundary; cleared at frame start, frame end and abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (clear) begin
            acc_r <= '0;
        end else if (bit_start) begin
            acc_r <= sum_s[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Runtime-programmable baud tick generator: mid-bit/end-of-bit ticks, bit index and frame pulse.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD_DEFAULT = 115200,
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int FRAME_BITS   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              busy,
    output logic              tick_mid,
    output logic              tick_end,
    output logic [3:0]        bit_idx,
    output logic              frame_done,
    output logic              cfg_err
);

    if (FRAME_BITS < FRAME_BITS_MIN || FRAME_BITS > FRAME_BITS_MAX) begin : g_bad_frame_bits
        $error("baud_tick_gen: FRAME_BITS out of range");
    end

    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(div_from_baud(CLK_FREQ_HZ, BAUD_DEFAULT));
    localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

    state_e            state_r, state_next_s;
    logic [DIV_W:0]    cnt_r, period_s, half_s;
    logic [DIV_W-1:0]  div_int_r, pend_int_r;
    logic [FRAC_W-1:0] div_frac_r, pend_frac_r;
    logic              pend_valid_r;
    logic [3:0]        bit_idx_r;
    logic run_s, start_s, abort_s, mid_s, end_s, last_s, load_ok_s, direct_s, apply_s;

    baud_frac_acc #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_frac_acc (
        .clk       (clk),
        .rst       (rst),
        .div_int   (div_int_r),
        .frac      (div_frac_r),
        .clear     (start_s || abort_s || last_s),
        .bit_start (end_s),
        .period    (period_s)
    );

    // Event decode: an abort edge (en low in RUN) produces no ticks.
    always_comb begin
        run_s     = (state_r == RUN) && en;
        start_s   = (state_r == IDLE) && en;
        abort_s   = (state_r == RUN) && !en;
        half_s    = period_s >> 1;
        mid_s     = run_s && (cnt_r == half_s);
        end_s     = run_s && (cnt_r == (period_s - {{DIV_W{1'b0}}, 1'b1}));
        last_s    = end_s && (bit_idx_r == LAST_BIT);
        load_ok_s = div_load && (div_int >= DIV_W'(2));
        direct_s  = ((state_r == IDLE) && !en) || abort_s;
        apply_s   = pend_valid_r && (last_s || abort_s);
    end

    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (en) state_next_s = RUN;  else state_next_s = IDLE;
            RUN:     if (!en) state_next_s = IDLE; else state_next_s = RUN;
            default: state_next_s = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bit counter and in-frame bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            bit_idx_r <= 4'd0;
        end else if (start_s || abort_s) begin
            cnt_r     <= '0;
            bit_idx_r <= 4'd0;
        end else if (end_s) begin
            cnt_r     <= '0;
            bit_idx_r <= last_s ? 4'd0 : bit_idx_r + 4'd1;
        end else if (run_s) begin
            cnt_r     <= cnt_r + {{DIV_W{1'b0}}, 1'b1};
        end
    end

    // Divisor loads: immediate when no frame can observe them, otherwise deferred to the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_int_r    <= DIV_RESET;
            div_frac_r   <= '0;
            pend_int_r   <= '0;
            pend_frac_r  <= '0;
            pend_valid_r <= 1'b0;
        end else if (load_ok_s && direct_s) begin
            div_int_r    <= div_int;
            div_frac_r   <= div_frac;
            pend_valid_r <= 1'b0;
        end else if (load_ok_s) begin
            if (apply_s) begin
                div_int_r  <= pend_int_r;
                div_frac_r <= pend_frac_r;
            end
            pend_int_r   <= div_int;
            pend_frac_r  <= div_frac;
            pend_valid_r <= 1'b1;
        end else if (apply_s) begin
            div_int_r    <= pend_int_r;
            div_frac_r   <= pend_frac_r;
            pend_valid_r <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_mid   <= 1'b0;
            tick_end   <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            tick_mid   <= mid_s;
            tick_end   <= end_s;
            frame_done <= last_s;
            cfg_err    <= div_load && (div_int < DIV_W'(2));
        end
    end

    assign busy    = (state_r == RUN);
    assign bit_idx = bit_idx_r;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Scoreboard bench for baud_tick_gen: expected pulses are queued with their cycle, a monitor pops and compares.
module tb_baud_tick_gen;

    localparam int FRAME_BITS = 10;
    localparam int K_MID = 0, K_END = 1, K_DONE = 2, K_ERR = 3;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, div_load = 1'b0;
    logic [15:0] div_int = 16'd0;
    logic [3:0]  div_frac = 4'd0;
    logic        busy, tick_mid, tick_end, frame_done, cfg_err;
    logic [3:0]  bit_idx;

    baud_tick_gen #(
        .CLK_FREQ_HZ(100_000_000), .BAUD_DEFAULT(115200),
        .DIV_W(16), .FRAC_W(4), .FRAME_BITS(FRAME_BITS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .div_load(div_load), .div_int(div_int),
        .div_frac(div_frac), .busy(busy), .tick_mid(tick_mid), .tick_end(tick_end),
        .bit_idx(bit_idx), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int kind; int at; int idx; } ev_t;
    ev_t q[$];
    int checks = 0, passed = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    endtask

    task automatic push(input int kind, input int at, input int idx);
        ev_t e;
        e.kind = kind; e.at = at; e.idx = idx;
        q.push_back(e);
    endtask

    task automatic observe(input int kind, input int idx);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_pulse kind %0d at cycle %0d: got pulse expected none", kind, cyc);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_cycle", cyc, e.at);
            if (e.idx >= 0) check("bit_idx_at_end", idx, e.idx);
        end
    endtask

    // Monitor: one queue entry per observed pulse, in mid/end/done/err order within a cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (tick_mid)   observe(K_MID, -1);
            if (tick_end)   observe(K_END, int'(bit_idx));
            if (frame_done) observe(K_DONE, -1);
            if (cfg_err)    observe(K_ERR, -1);
        end
    end

    // Reference timing: bit starting at edge t with period p gives mid at t+p/2+1, end at t+p.
    task automatic push_frames(input int e0, input int dint, input int frac,
                               input int nframes, output int t_end);
        int t, acc, s, p;
        t = e0;
        for (int f = 0; f < nframes; f++) begin
            acc = 0;
            for (int b = 0; b < FRAME_BITS; b++) begin
                s   = acc + frac;
                p   = dint + s / 16;
                acc = s % 16;
                push(K_MID, t + p / 2 + 1, -1);
                push(K_END, t + p, (b + 1) % FRAME_BITS);
                if (b == FRAME_BITS - 1) push(K_DONE, t + p, -1);
                t = t + p;
            end
        end
        t_end = t;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int di, input int df);
        div_int = 16'(di); div_frac = 4'(df); div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    task automatic stop_at(input int edge_n);
        while (cyc < edge_n - 1) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    int e0, t, t2;

    initial begin
        tick(3);
        check("reset_outputs", int'({busy, tick_mid, tick_end, frame_done, cfg_err, bit_idx}), 0);
        rst = 1'b0;
        tick(2);
        check("idle_outputs", int'({busy, tick_mid, tick_end, frame_done, cfg_err, bit_idx}), 0);

        // Default divisor 868 out of reset
        e0 = cyc + 1; en = 1'b1;
        push(K_MID, e0 + 435, -1);
        push(K_END, e0 + 868, 1);
        stop_at(e0 + 900);
        check("default_abort_busy", int'(busy), 0);

        // Integer divisor 4, full frame
        load(4, 0); tick(2);
        e0 = cyc + 1; en = 1'b1;
        push_frames(e0, 4, 0, 1, t);
        stop_at(t + 1);
        tick(3);

        // Abort on the edge after the third tick_end
        e0 = cyc + 1; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(K_MID, e0 + 4 * k + 3, -1);
            push(K_END, e0 + 4 * k + 4, k + 1);
        end
        stop_at(e0 + 13);
        check("abort_busy", int'(busy), 0);
        check("abort_bit_idx", int'(bit_idx), 0);
        tick(10);
        e0 = cyc + 1; en = 1'b1;
        tick(1);
        check("restart_busy", int'(busy), 1);
        check("restart_bit_idx", int'(bit_idx), 0);
        push_frames(e0, 4, 0, 1, t);
        stop_at(t + 1);
        tick(2);

        // Illegal load rejected, divisor stays 4
        push(K_ERR, cyc + 1, -1);
        load(1, 0);
        tick(2);
        e0 = cyc + 1; en = 1'b1;
        push(K_MID, e0 + 3, -1); push(K_END, e0 + 4, 1);
        push(K_MID, e0 + 7, -1); push(K_END, e0 + 8, 2);
        stop_at(e0 + 9);
        tick(2);

        // Fractional 4.5: frames end at e0+45 and e0+90
        load(4, 8); tick(2);
        e0 = cyc + 1; en = 1'b1;
        push_frames(e0, 4, 8, 2, t);
        check("frac_two_frames", t - e0, 90);
        stop_at(t + 1);
        tick(2);

        // Deferred load of 6 during bit 2
        load(4, 0); tick(2);
        e0 = cyc + 1; en = 1'b1;
        push_frames(e0, 4, 0, 1, t);
        push_frames(t, 6, 0, 1, t2);
        while (cyc < e0 + 9) @(negedge clk);
        load(6, 0);
        stop_at(t2 + 1);
        tick(2);

        // Load coincident with en rising: first frame keeps 6, second uses 4
        div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1; en = 1'b1;
        e0 = cyc + 1;
        push_frames(e0, 6, 0, 1, t);
        push_frames(t, 4, 0, 1, t2);
        @(negedge clk);
        div_load = 1'b0;
        stop_at(t2 + 1);

        tick(5);
        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
